// File: rtl/multi_channel_clock_divider_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// The package name matches the other divider blocks in the codebase.
package clock_divider_pkg;

  // Channel output behaviour at each terminal count.
  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Default counter width and reset divisor: 50 MHz / 50e6 gives a 1 Hz tick.
  localparam int          DEFAULT_CNT_W   = 28;
  localparam logic [27:0] DEFAULT_DIV_VAL = 28'd49_999_999;

endpackage

// File: rtl/multi_channel_clock_divider_channel.sv
// One divider channel: counter, active and shadow divisor/mode, and outputs.
// A shadow write never disturbs the period in progress. It becomes active at
// the next terminal count or restart.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int               CNT_W       = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_VAL)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             restart,
  input  logic [CNT_W-1:0] load_div,
  input  logic             load_mode,
  output logic             out_level,
  output logic             out_tick,
  output logic             pending
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_div_sh;
  mode_e            r_mode;
  mode_e            r_mode_sh;
  logic             r_pend;
  logic             r_level;
  logic             r_tick;

  // The counter never passes the divisor, so equality is the terminal condition.
  logic w_terminal;
  assign w_terminal = (r_cnt == r_div);

  // Counter, shadow hand-over and output registers.
  // A restart takes priority over counting, so a restart on the terminal edge
  // produces no tick and no toggle.
  // A load that lands on a terminal edge does not feed the value being consumed.
  // The old shadow goes active, and the new write stays pending for the next period.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_div     <= DEFAULT_DIV;
      r_div_sh  <= DEFAULT_DIV;
      r_mode    <= MODE_TOGGLE;
      r_mode_sh <= MODE_TOGGLE;
      r_pend    <= 1'b0;
      r_level   <= 1'b1;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (restart) begin
        r_cnt <= '0;
        if (load) begin
          r_div     <= load_div;
          r_mode    <= mode_e'(load_mode);
          r_div_sh  <= load_div;
          r_mode_sh <= mode_e'(load_mode);
          r_pend    <= 1'b0;
        end else if (r_pend) begin
          r_div  <= r_div_sh;
          r_mode <= r_mode_sh;
          r_pend <= 1'b0;
        end
      end else begin
        if (enable) begin
          if (w_terminal) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            if (r_mode == MODE_TOGGLE) begin
              r_level <= ~r_level;
            end
            if (r_pend) begin
              r_div  <= r_div_sh;
              r_mode <= r_mode_sh;
              r_pend <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        if (load) begin
          r_div_sh  <= load_div;
          r_mode_sh <= mode_e'(load_mode);
          r_pend    <= 1'b1;
        end
      end
    end
  end

  assign out_level = r_level;
  assign out_tick  = r_tick;
  assign pending   = r_pend;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// Multi-channel clock divider top level.
// It decodes the shared load/restart strobes into per-channel strobes and
// instantiates one divider channel per output. A channel select beyond the
// last channel matches no channel and is therefore ignored.
module multi_channel_clock_divider
  import clock_divider_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter int               CNT_W       = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_VAL),
  parameter int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_div,
  input  logic              load_mode,
  input  logic              restart,
  output logic [NUM_CH-1:0] out_level,
  output logic [NUM_CH-1:0] out_tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] w_ch_sel;
  logic [NUM_CH-1:0] w_load_hit;
  logic [NUM_CH-1:0] w_restart_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_ch_sel[gi]      = (load_ch == CH_W'(gi));
      assign w_load_hit[gi]    = load & w_ch_sel[gi];
      assign w_restart_hit[gi] = restart & w_ch_sel[gi];

      clock_divider_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_channel (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable[gi]),
        .load      (w_load_hit[gi]),
        .restart   (w_restart_hit[gi]),
        .load_div  (load_div),
        .load_mode (load_mode),
        .out_level (out_level[gi]),
        .out_tick  (out_tick[gi]),
        .pending   (pending[gi])
      );
    end
  endgenerate

endmodule

// File: doc/multi_channel_clock_divider.md
# multi_channel_clock_divider

Parametrised, multi-channel successor to the single-channel LED clock divider. Derives NUM_CH independent slow outputs from the system clock. Each channel has its own runtime-programmable divisor, a toggle or pulse mode, and an enable. Sits between the system clock domain and the LED/display and simulator-tick consumers; all outputs are synchronous to `clock`.

## Interface
- NUM_CH, 4, number of independent divider channels (1..16)
- CNT_W, 28, counter/divisor width in bits
- DEFAULT_DIV, 28'd49_999_999, divisor loaded into every channel at reset
- CH_W, $clog2(NUM_CH) (minimum 1), width of the channel-select field

- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- enable  in  NUM_CH  per-channel count enable; counter and level hold while low
- load  in  1  write strobe for the shadow divisor/mode of channel `load_ch`
- load_ch  in  CH_W  target channel of `load`/`restart`
- load_div  in  CNT_W  new divisor N; period is N+1 enabled cycles
- load_mode  in  1  0 = toggle (square wave), 1 = pulse (single-cycle tick)
- restart  in  1  clear counter of `load_ch` and apply pending shadow immediately
- out_level  out  NUM_CH  per-channel toggle output
- out_tick  out  NUM_CH  per-channel one-cycle pulse at each terminal count
- pending  out  NUM_CH  shadow value written but not yet active

## Operation
- Per-channel state: `cnt`, active `div`/`mode`, shadow `div_sh`/`mode_sh`, `pend`.
- Reset values: cnt=0, div=div_sh=DEFAULT_DIV, mode=mode_sh=toggle, pend=0, out_level=all 1, out_tick=0, pending=0.
- Counting, enabled edge: if cnt==div, then terminal: cnt<=0. Otherwise cnt<=cnt+1. Disabled edge: all channel state holds and tick is 0.
- Terminal event: out_tick<=1 for exactly one cycle in both modes. out_level toggles only in toggle mode; in pulse mode it holds its current value. If pend is set, div<=div_sh, mode<=mode_sh and pend<=0 on the same edge. The new divisor governs the next period.
- Load: `load` with load_ch<NUM_CH writes div_sh/mode_sh and sets pend. A load to load_ch>=NUM_CH is ignored. A second load before the terminal count overwrites the shadow; last write wins.
- Restart: a restart of a valid channel sets cnt<=0 and out_tick<=0, applies the shadow if pend (pend<=0), and leaves out_level unchanged. Restart is independent of enable.
- Simultaneous load+restart, same channel: the loaded value becomes active on that edge; pend ends 0.
- Restart coinciding with terminal count: restart wins, no tick.
- div=0: terminal every enabled cycle. In toggle mode, level toggles every cycle; in pulse mode, tick stays high while enabled.
- Arithmetic: unsigned CNT_W, no overflow possible because cnt never exceeds div.

## Timing
- Terminal edges fall every N+1 enabled edges. The first one after reset or restart is the (N+1)th enabled edge.
- out_tick is registered: high for the cycle after the terminal edge.
- Toggle mode: out_level period 2(N+1) enabled cycles, 50% duty.
- Divisor change latency: takes effect at the next terminal edge, or on the restart edge. A load never shortens or truncates a period in progress (glitch-free).
- pending rises the cycle after `load` and falls the cycle after the terminal or restart edge that consumes it.
- Reset mid-operation: all channels return to reset values on the next edge, regardless of other inputs.

## Structure
- Package `clock_divider_pkg`: mode constants (MODE_TOGGLE=1'b0, MODE_PULSE=1'b1), default CNT_W, default DEFAULT_DIV.
- Sub-module `clock_divider_channel`: one channel's counter, active/shadow registers and outputs; NUM_CH instances generated. The top level only decodes load/restart into per-channel strobes.

## Test plan
- Reset with DEFAULT_DIV=3, enable all: out_tick pulses after the 4th, 8th, … edge. out_level goes 1→0 at edge 4 and 0→1 at edge 8.
- Load ch1 div=1, pulse mode, at cycle 2 of a div=3 period: current period completes (tick at edge 4), then ticks every 2 cycles. out_level holds; pending is 1 from cycle 3 until after edge 4.
- Enable ch0 toggled 1,0,0,1,…: counter holds during gaps. Terminal lands exactly on the 4th enabled edge.
- Load ch2 div=7 together with restart ch2 mid-count: cnt clears and pending never asserts. Next tick arrives 8 enabled edges later.
- Load with load_ch=NUM_CH (NUM_CH=4, CH_W=3): no channel state changes.
- Assert reset mid-period with ticks pending: next cycle all out_level=1, out_tick=0, pending=0, divisors=DEFAULT_DIV.
